// File: rtl/count_event_monitor.sv
// Watches an up/down counter's output and control inputs, classifies each cycle's
// transition (load, wrap, threshold hit) and queues events in a small FWFT FIFO.
module count_event_monitor #(
  parameter int unsigned NBITS = 4,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NBITS-1:0]         q_in,
  input  logic                     load_in,
  input  logic                     up_down_in,
  input  logic [NBITS-1:0]         thresh,
  input  logic                     enable,
  input  logic                     evt_ready,
  input  logic                     drop_clr,
  output logic                     evt_valid,
  output logic [1:0]               evt_code,
  output logic [NBITS-1:0]         evt_value,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     drop_sticky,
  output logic [7:0]               drop_cnt
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;

  localparam logic [1:0] EvThresh   = 2'd0;
  localparam logic [1:0] EvWrapUp   = 2'd1;
  localparam logic [1:0] EvWrapDown = 2'd2;
  localparam logic [1:0] EvLoad     = 2'd3;

  localparam logic [NBITS-1:0] AllOnes = {NBITS{1'b1}};
  localparam logic [NBITS-1:0] AllZero = {NBITS{1'b0}};

  logic [NBITS-1:0] prev_q;
  logic             load_d;
  logic             dir_d;
  logic             armed;

  logic [1:0]       code_mem  [DEPTH];
  logic [NBITS-1:0] value_mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [LW-1:0]    occ;

  logic             det;
  logic [1:0]       det_code;
  logic             full;
  logic             pop;
  logic             push;
  logic             drop;

  // Registered controls line up with q_in, which already reflects the counter's update.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prev_q <= '0;
      load_d <= 1'b0;
      dir_d  <= 1'b0;
      armed  <= 1'b0;
    end else begin
      prev_q <= q_in;
      load_d <= load_in;
      dir_d  <= up_down_in;
      armed  <= enable;
    end
  end

  always_comb begin
    det      = 1'b0;
    det_code = EvThresh;
    if (enable && armed) begin
      if (load_d) begin
        det      = 1'b1;
        det_code = EvLoad;
      end else if (dir_d && prev_q == AllOnes && q_in == AllZero) begin
        det      = 1'b1;
        det_code = EvWrapUp;
      end else if (!dir_d && prev_q == AllZero && q_in == AllOnes) begin
        det      = 1'b1;
        det_code = EvWrapDown;
      end else if (q_in == thresh && prev_q != thresh) begin
        det      = 1'b1;
        det_code = EvThresh;
      end
    end
  end

  assign full      = (occ == LW'(DEPTH));
  assign evt_valid = (occ != '0);
  assign level     = occ;
  assign pop       = evt_valid && evt_ready;
  assign push      = det && (!full || pop);
  assign drop      = det && full && !pop;

  always_ff @(posedge clk) begin
    if (push) begin
      code_mem[wr_ptr]  <= det_code;
      value_mem[wr_ptr] <= q_in;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      if (push && !pop)      occ <= occ + LW'(1);
      else if (pop && !push) occ <= occ - LW'(1);
    end
  end

  // Gate the head with valid so the outputs read zero out of reset and when empty.
  always_comb begin
    evt_code  = '0;
    evt_value = '0;
    if (evt_valid) begin
      evt_code  = code_mem[rd_ptr];
      evt_value = value_mem[rd_ptr];
    end
  end

  // A drop coinciding with a clear restarts the tally at one.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      drop_sticky <= 1'b0;
      drop_cnt    <= '0;
    end else if (drop_clr) begin
      drop_sticky <= drop;
      drop_cnt    <= drop ? 8'd1 : 8'd0;
    end else if (drop) begin
      drop_sticky <= 1'b1;
      if (drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'd1;
    end
  end

endmodule
